// File: rtl/pl_sysref_pkg.sv
// Shared definitions for the SYSREF alignment block.
// Holds the alignment FSM state type and the default widths and thresholds
// used as parameter defaults by pl_sysref_align.
package pl_sysref_pkg;

  localparam int unsigned DEF_PERIOD_W   = 16;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_TOL        = 1;

  // Wide enough for LOCK_COUNT up to 255.
  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2
  } state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both stages
//   d   - asynchronous input bit
//   q   - synchronised output (second stage)
module cdc_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic s1_q;
  (* ASYNC_REG = "TRUE" *) logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pl_sysref_align.sv
// SYSREF period qualification and aligned sync-pulse generation.
// Synchronises the external SYSREF, measures the edge-to-edge period,
// locks after LOCK_COUNT consecutive in-tolerance periods and, once locked,
// emits a single sync pulse on the edge following an arm request.
// Ports:
//   clk         - fabric clock, all logic on rising edge
//   rst         - synchronous active-high reset
//   sysref_in   - SYSREF, asynchronous to clk
//   period_exp  - expected SYSREF period in clk cycles (0 holds the FSM in hunt)
//   arm         - one-cycle request for one aligned sync pulse
//   err_clr     - one-cycle clear of the sticky error flag
//   sync_pulse  - one-cycle pulse the cycle after a qualified edge
//   locked      - high while locked
//   armed       - high while an arm request is pending
//   err         - sticky loss-of-lock / timeout flag
//   period_meas - most recently measured period
module pl_sysref_align
  import pl_sysref_pkg::*;
#(
  parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned TOL        = DEF_TOL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sysref_in,
  input  logic [PERIOD_W-1:0] period_exp,
  input  logic                arm,
  input  logic                err_clr,
  output logic                sync_pulse,
  output logic                locked,
  output logic                armed,
  output logic                err,
  output logic [PERIOD_W-1:0] period_meas
);

  localparam logic [PERIOD_W:0]   TolExt  = (PERIOD_W + 1)'(TOL);
  localparam logic [LOCK_CNT_W-1:0] LockTgt = LOCK_CNT_W'(LOCK_COUNT);

  state_e                state_q, state_d;
  logic                  s2, s3_q, sref_edge;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [PERIOD_W-1:0]   pm_q, pm_d;
  logic [LOCK_CNT_W-1:0] lk_q, lk_d, lk_inc;
  logic                  armed_q, armed_d;
  logic                  pulse_q, pulse_d;
  logic                  err_q, err_d;
  logic                  err_event;

  logic [PERIOD_W:0]     meas_ext, exp_ext, dev, limit;
  logic [PERIOD_W-1:0]   meas_sat;
  logic                  in_tol, timeout;

  cdc_sync_bit u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sysref_in),
    .q   (s2)
  );

  assign sref_edge = s2 & ~s3_q;

  // Period arithmetic is done one bit wider so cnt+1 never wraps.
  assign meas_ext = {1'b0, cnt_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign exp_ext  = {1'b0, period_exp};
  assign dev      = (meas_ext >= exp_ext) ? (meas_ext - exp_ext) : (exp_ext - meas_ext);
  assign in_tol   = (dev <= TolExt);
  assign limit    = exp_ext + TolExt;
  // Fires as soon as an edge arriving now could no longer be in tolerance.
  assign timeout  = ~sref_edge & (meas_ext > limit);
  assign meas_sat = meas_ext[PERIOD_W] ? {PERIOD_W{1'b1}} : meas_ext[PERIOD_W-1:0];
  assign lk_inc   = lk_q + {{(LOCK_CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    lk_d      = lk_q;
    pm_d      = pm_q;
    armed_d   = armed_q;
    pulse_d   = 1'b0;
    err_event = 1'b0;

    if (sref_edge) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
    end

    unique case (state_q)
      StHunt: begin
        // The first edge only starts the measurement; no period yet.
        if (sref_edge) begin
          state_d = StTrack;
          lk_d    = '0;
        end
      end
      StTrack: begin
        if (sref_edge) begin
          pm_d = meas_sat;
          if (in_tol) begin
            if (lk_inc >= LockTgt) begin
              state_d = StLocked;
              lk_d    = '0;
            end else begin
              lk_d = lk_inc;
            end
          end else begin
            lk_d = '0;
          end
        end
      end
      StLocked: begin
        if (sref_edge) begin
          pm_d = meas_sat;
          if (in_tol) begin
            if (armed_q) begin
              pulse_d = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            state_d   = StHunt;
            err_event = 1'b1;
          end
        end else if (timeout) begin
          state_d   = StHunt;
          err_event = 1'b1;
        end
      end
      default: begin
        state_d = StHunt;
        lk_d    = '0;
      end
    endcase

    // No expected period means nothing to qualify against.
    if (period_exp == '0) begin
      state_d   = StHunt;
      lk_d      = '0;
      err_event = 1'b0;
    end

    // Arm sampled on an edge cycle is registered after that edge's decision,
    // so it applies to the following edge.
    if (arm && (state_q == StLocked) && (state_d == StLocked)) begin
      armed_d = 1'b1;
    end

    if (state_d != StLocked) begin
      armed_d = 1'b0;
      pulse_d = 1'b0;
    end

    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (err_event) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      pm_q    <= '0;
      lk_q    <= '0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s3_q    <= s2;
      cnt_q   <= cnt_d;
      pm_q    <= pm_d;
      lk_q    <= lk_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign sync_pulse  = pulse_q;
  assign locked      = (state_q == StLocked);
  assign armed       = armed_q;
  assign err         = err_q;
  assign period_meas = pm_q;

endmodule

// File: tb/tb_pl_sysref_align.sv
module tb_pl_sysref_align;

  logic        clk;
  logic        rst;
  logic        sysref_in;
  logic [15:0] period_exp;
  logic        arm;
  logic        err_clr;
  logic        sync_pulse;
  logic        locked;
  logic        armed;
  logic        err;
  logic [15:0] period_meas;

  pl_sysref_align #(
    .PERIOD_W   (16),
    .LOCK_COUNT (4),
    .TOL        (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sysref_in   (sysref_in),
    .period_exp  (period_exp),
    .arm         (arm),
    .err_clr     (err_clr),
    .sync_pulse  (sync_pulse),
    .locked      (locked),
    .armed       (armed),
    .err         (err),
    .period_meas (period_meas)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected sync_pulse cycles.
  int exp_q[$];
  int mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SYSREF generator: rises every gen_period cycles, high for 3 cycles.
  int gen_period = 0;
  int ph         = 0;
  int rises      = 0;
  int last_rise  = 0;

  initial begin
    sysref_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_period == 0) begin
        sysref_in = 1'b0;
        ph = 0;
      end else begin
        if (ph == 0) begin
          sysref_in = 1'b1;
          last_rise = cyc;
          rises++;
        end else if (ph == 3) begin
          sysref_in = 1'b0;
        end
        ph = (ph + 1 >= gen_period) ? 0 : ph + 1;
      end
    end
  end

  // Scoreboard side: every observed pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (sync_pulse === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL pulse_unexpected: observed pulse at cyc=%0d, expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        total++;
        assert (cyc == mon_e) else begin
          bad++;
          $error("FAIL pulse_cycle: observed cyc=%0d expected cyc=%0d", cyc, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_rise(output int r);
    int n0;
    n0 = rises;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises != n0) break;
    end
    total++;
    assert (rises != n0) else begin
      bad++;
      $error("FAIL wait_rise: observed no rise in 200 cycles, expected a rise");
    end
    r = last_rise;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int r;
  int ra;

  initial begin
    rst        = 1'b1;
    period_exp = 16'd10;
    arm        = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_armed", armed, 0);
    check("rst_err", err, 0);
    check("rst_pulse", sync_pulse, 0);
    check("rst_pmeas", period_meas, 0);
    rst = 1'b0;

    // Lock on period 10: 5th edge locks.
    gen_period = 10;
    repeat (4) wait_rise(r);
    wait_rise(r);
    wait_until(r + 2);
    check("lock_early", locked, 0);
    wait_until(r + 3);
    check("lock_rise", locked, 1);
    check("lock_pmeas", period_meas, 10);
    check("lock_err", err, 0);

    // Arm mid-period, pulse the cycle after the next edge detect.
    arm = 1'b1;
    exp_q.push_back(r + 10 + 3);
    @(negedge clk);
    arm = 1'b0;
    check("arm_set", armed, 1);
    wait_rise(r);
    wait_until(r + 2);
    check("arm_pre_armed", armed, 1);
    check("arm_pre_pulse", sync_pulse, 0);
    wait_until(r + 3);
    check("arm_pulse", sync_pulse, 1);
    check("arm_cleared", armed, 0);
    wait_until(r + 4);
    check("arm_pulse_width", sync_pulse, 0);

    // Arm coincident with an edge applies to the following edge.
    wait_rise(r);
    wait_until(r + 2);
    arm = 1'b1;
    exp_q.push_back(r + 10 + 3);
    wait_until(r + 3);
    arm = 1'b0;
    check("coinc_no_pulse", sync_pulse, 0);
    check("coinc_armed", armed, 1);
    wait_rise(r);
    wait_until(r + 3);
    check("coinc_cleared", armed, 0);

    // Period 11 stays within tolerance.
    gen_period = 11;
    wait_rise(r);
    gen_period = 10;
    wait_until(r + 3);
    check("p11_locked", locked, 1);
    check("p11_pmeas", period_meas, 11);
    check("p11_err", err, 0);

    // Period 12 breaks lock; armed must not produce a pulse.
    gen_period = 12;
    wait_until(r + 4);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("p12_armed", armed, 1);
    wait_rise(r);
    gen_period = 10;
    wait_until(r + 2);
    check("p12_pre_locked", locked, 1);
    wait_until(r + 3);
    check("p12_locked", locked, 0);
    check("p12_err", err, 1);
    check("p12_armed_clr", armed, 0);
    check("p12_pmeas", period_meas, 12);

    // Relock, then timeout collides with err_clr.
    repeat (5) wait_rise(r);
    wait_until(r + 3);
    check("relock1", locked, 1);
    check("relock1_err_sticky", err, 1);
    wait_until(r + 4);
    arm = 1'b1;
    gen_period = 0;
    @(negedge clk);
    arm = 1'b0;
    wait_until(r + 14);
    err_clr = 1'b1;
    check("coll_pre_locked", locked, 1);
    check("coll_pre_armed", armed, 1);
    wait_until(r + 15);
    err_clr = 1'b0;
    check("coll_err", err, 1);
    check("coll_locked", locked, 0);
    check("coll_armed", armed, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clear", err, 0);

    // Relock, stop SYSREF: err rises when cnt reaches 11.
    gen_period = 10;
    repeat (5) wait_rise(r);
    wait_until(r + 3);
    check("relock2", locked, 1);
    wait_until(r + 4);
    arm = 1'b1;
    gen_period = 0;
    @(negedge clk);
    arm = 1'b0;
    wait_until(r + 14);
    check("to_pre_err", err, 0);
    check("to_pre_locked", locked, 1);
    check("to_pre_armed", armed, 1);
    wait_until(r + 15);
    check("to_err", err, 1);
    check("to_locked", locked, 0);
    check("to_armed", armed, 0);

    // Reset mid-period with armed high, then full re-lock.
    gen_period = 10;
    repeat (5) wait_rise(r);
    wait_until(r + 3);
    check("relock3", locked, 1);
    wait_until(r + 4);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("rst_mid_armed", armed, 1);
    wait_until(r + 6);
    rst = 1'b1;
    wait_until(r + 7);
    check("rstm_locked", locked, 0);
    check("rstm_armed", armed, 0);
    check("rstm_err", err, 0);
    check("rstm_pmeas", period_meas, 0);
    check("rstm_pulse", sync_pulse, 0);
    wait_until(r + 8);
    rst = 1'b0;
    wait_rise(ra);
    wait_until(ra + 3);
    check("rstm_first_edge_locked", locked, 0);
    check("rstm_first_edge_pmeas", period_meas, 0);
    repeat (3) wait_rise(r);
    wait_rise(r);
    wait_until(r + 2);
    check("rstm_relock_early", locked, 0);
    wait_until(r + 3);
    check("rstm_relock", locked, 1);
    check("rstm_relock_pmeas", period_meas, 10);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
